mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage controller between the EX_MEM/MEM_WB buffers and a variable-latency data memory bus.
- Converts the MEM-stage load or store into a req/ack bus transaction.
- Produces the mem_stall hazard condition consumed by the hazard unit, holding the whole pipeline until the access completes or times out.
- Returns load data and a timeout error flag; the flag feeds the alert path.

Parameters:
- ADDR_W, 32, width of the data address.
- DATA_W, 32, width of data words.
- TIMEOUT, 255, number of WAIT cycles without bus_ack before the access is aborted. Legal range 1..1023.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- mem_rd  in  1  MEM-stage instruction is a load.
- mem_wr  in  1  MEM-stage instruction is a store.
- mem_addr  in  ADDR_W  MEM-stage effective address.
- mem_wdata  in  DATA_W  MEM-stage store data.
- bus_ack  in  1  memory completes the current request this cycle.
- bus_rdata  in  DATA_W  read data; valid when bus_ack=1.
- bus_req  out  1  registered; request active.
- bus_we  out  1  registered; 1=write, 0=read.
- bus_addr  out  ADDR_W  registered, latched address.
- bus_wdata  out  DATA_W  registered, latched write data.
- mem_stall  out  1  combinational; to hazard unit.
- mem_rdata  out  DATA_W  registered load result.
- mem_err  out  1  registered; one-cycle pulse on timeout.

Behaviour:
- Reset (rst_n=0 at an edge, from any state):
  - state goes to IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata, mem_rdata, mem_err and the timeout counter all go to 0.
  - Any in-flight bus transaction is abandoned with no completion.
- Access definition: access = mem_rd | mem_wr. mem_wr has priority; if both are 1, the access is a write.
- mem_stall is 1 when (state==IDLE && access) or state==WAIT; otherwise 0. It must be combinational so the pipeline freezes in the same cycle the access reaches MEM.
- IDLE:
  - If access, go to WAIT.
  - On that edge: bus_req<=1; bus_we<=mem_wr; latch mem_addr into bus_addr and mem_wdata into bus_wdata; counter<=0.
  - If no access, stay in IDLE with bus_req=0.
- WAIT:
  - bus_req, bus_we, bus_addr and bus_wdata are held stable. Later changes on mem_* inputs are ignored, including a flush of the EX_MEM buffer during a stall.
  - If bus_ack=1:
    - go to DONE and bus_req<=0;
    - on a read, mem_rdata<=bus_rdata;
    - on a write, mem_rdata is unchanged.
  - Else if counter==TIMEOUT-1: go to DONE, bus_req<=0, mem_err<=1, mem_rdata<=0 (read only).
  - Else counter increments.
  - bus_ack is allowed in the first WAIT cycle (zero wait states).
- DONE:
  - mem_stall=0 for exactly one cycle, so the completed instruction leaves MEM on this edge.
  - mem_err is 1 only in this cycle if a timeout occurred.
  - Next state is always IDLE; mem_err<=0. The following instruction is evaluated in IDLE, giving no extra pipeline bubble.
- bus_ack outside WAIT is ignored, with no state or data change.
- Minimum stall is 2 cycles (IDLE-detect plus one WAIT). A stall with N wait cycles before ack lasts N+1 cycles.
- mem_rdata holds its last load value until the next completed read or reset.
- Counter width is 10 bits. It never wraps in WAIT because TIMEOUT is at most 1023.

Test Plan:
- Reset hold: rst_n=0 for 3 cycles with mem_rd=1 and bus_ack=1 -> bus_req=0, mem_rdata=0, mem_err=0, mem_stall=0 during reset; after release, mem_stall=1 in the first cycle.
- Zero-wait load: mem_rd=1, addr=0x100; bus_ack=1 with rdata=0xDEADBEEF in the first WAIT cycle -> mem_stall=1 for 2 cycles; bus_req=1 for 1 cycle with bus_we=0 and bus_addr=0x100; in DONE, mem_rdata=0xDEADBEEF and mem_stall=0.
- Wait-state store: mem_wr=1, addr=0x200, wdata=0x12345678; ack after 3 WAIT cycles; change mem_addr mid-WAIT -> bus_addr stays 0x200, bus_we=1, mem_stall=1 for 4 cycles, mem_rdata unchanged.
- Back-to-back: a load then an immediately following store -> DONE gives one non-stall cycle, then IDLE re-stalls for the store; both bus transactions are correct; a spurious bus_ack in the DONE cycle is ignored.
- Timeout: TIMEOUT=4, mem_rd=1, bus_ack never asserted -> 4 WAIT cycles, then bus_req=0; in DONE, mem_err=1 for 1 cycle and mem_rdata=0; a later normal load succeeds.
- Reset mid-WAIT, plus rd+wr together: pulse rst_n=0 during WAIT -> IDLE with bus_req=0 next cycle. Then mem_rd=1 and mem_wr=1 together -> bus_we=1 (write wins).

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: turns a load/store into a req/ack
// bus transaction, stalls the pipeline while it is outstanding, and times out.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                req_nxt, we_nxt, err_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt, rdata_nxt;
  logic                access;

  assign access = mem_rd | mem_wr;

  // Stall is forced low while reset is held so the pipeline can flush freely.
  assign mem_stall = rst_n & (((state == IDLE) & access) | (state == WAIT));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bus_req   <= req_nxt;
      bus_we    <= we_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
      mem_rdata <= rdata_nxt;
      mem_err   <= err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = bus_req;
    we_nxt    = bus_we;
    addr_nxt  = bus_addr;
    wdata_nxt = bus_wdata;
    rdata_nxt = mem_rdata;
    err_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        req_nxt = 1'b0;
        if (access) begin
          state_nxt = WAIT;
          req_nxt   = 1'b1;
          we_nxt    = mem_wr;
          addr_nxt  = mem_addr;
          wdata_nxt = mem_wdata;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          if (!bus_we) rdata_nxt = bus_rdata;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          if (!bus_we) rdata_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4; inputs change 1 time unit
// after each rising edge and outputs are checked 1 unit later.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_rd, mem_wr, bus_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, bus_rdata;
  logic              bus_req, bus_we, mem_stall, mem_err;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .mem_stall(mem_stall),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset hold with a pending load and a spurious ack
    rst_n = 1'b0; mem_rd = 1'b1; mem_wr = 1'b0; bus_ack = 1'b1;
    mem_addr = 32'h100; mem_wdata = '0; bus_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      check("rst_req", bus_req, 0);
      check("rst_rdata", mem_rdata, 0);
      check("rst_err", mem_err, 0);
      check("rst_stall", mem_stall, 0);
    end

    // Zero-wait load: first cycle after release is the IDLE detect
    rst_n = 1'b1; bus_ack = 1'b0; settle();
    check("ld0_idle_stall", mem_stall, 1);
    check("ld0_idle_req", bus_req, 0);
    step(); bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; settle();
    check("ld0_wait_stall", mem_stall, 1);
    check("ld0_wait_req", bus_req, 1);
    check("ld0_wait_we", bus_we, 0);
    check("ld0_wait_addr", bus_addr, 32'h100);
    step(); mem_rd = 1'b0; bus_ack = 1'b0; settle();
    check("ld0_done_stall", mem_stall, 0);
    check("ld0_done_req", bus_req, 0);
    check("ld0_done_rdata", mem_rdata, 32'hDEAD_BEEF);

    // Store with ack in the third WAIT cycle; address changes mid-WAIT
    step(); mem_wr = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h1234_5678; settle();
    check("st_idle_stall", mem_stall, 1);
    for (int w = 0; w < 3; w++) begin
      step(); mem_addr = 32'h999 + 32'(w); mem_wdata = 32'hFFFF_0000;
      bus_ack = (w == 2); settle();
      check("st_wait_stall", mem_stall, 1);
      check("st_wait_req", bus_req, 1);
      check("st_wait_we", bus_we, 1);
      check("st_wait_addr", bus_addr, 32'h200);
      check("st_wait_wdata", bus_wdata, 32'h1234_5678);
    end
    step(); mem_wr = 1'b0; bus_ack = 1'b0;
    mem_rd = 1'b1; mem_addr = 32'h300; settle();
    check("st_done_stall", mem_stall, 0);
    check("st_done_req", bus_req, 0);
    check("st_done_rdata", mem_rdata, 32'hDEAD_BEEF);

    // Back-to-back load then store, spurious ack during DONE
    step(); settle();
    check("bb_ld_idle_stall", mem_stall, 1);
    step(); bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D; settle();
    check("bb_ld_wait_addr", bus_addr, 32'h300);
    check("bb_ld_wait_we", bus_we, 0);
    step(); mem_rd = 1'b0; mem_wr = 1'b1; mem_addr = 32'h400;
    mem_wdata = 32'hA5A5_A5A5; bus_rdata = 32'h7777_7777; settle();
    check("bb_ld_done_stall", mem_stall, 0);
    check("bb_ld_done_rdata", mem_rdata, 32'hCAFE_F00D);
    step(); bus_ack = 1'b0; settle();
    check("bb_st_idle_stall", mem_stall, 1);
    check("bb_st_idle_req", bus_req, 0);
    check("bb_spurious_rdata", mem_rdata, 32'hCAFE_F00D);
    step(); bus_ack = 1'b1; settle();
    check("bb_st_wait_req", bus_req, 1);
    check("bb_st_wait_we", bus_we, 1);
    check("bb_st_wait_addr", bus_addr, 32'h400);
    check("bb_st_wait_wdata", bus_wdata, 32'hA5A5_A5A5);
    step(); mem_wr = 1'b0; bus_ack = 1'b0;
    mem_rd = 1'b1; mem_addr = 32'h500; settle();
    check("bb_st_done_stall", mem_stall, 0);
    check("bb_st_done_rdata", mem_rdata, 32'hCAFE_F00D);

    // Timeout: four WAIT cycles with no ack
    step(); settle();
    check("to_idle_stall", mem_stall, 1);
    for (int w = 0; w < 4; w++) begin
      step(); settle();
      check("to_wait_req", bus_req, 1);
      check("to_wait_stall", mem_stall, 1);
      check("to_wait_err", mem_err, 0);
    end
    step(); mem_rd = 1'b0; settle();
    check("to_done_req", bus_req, 0);
    check("to_done_err", mem_err, 1);
    check("to_done_rdata", mem_rdata, 0);
    check("to_done_stall", mem_stall, 0);
    step(); mem_rd = 1'b1; mem_addr = 32'h600; settle();
    check("to_err_cleared", mem_err, 0);
    step(); bus_ack = 1'b1; bus_rdata = 32'h0BAD_CAFE; settle();
    check("to_ld_addr", bus_addr, 32'h600);
    step(); mem_rd = 1'b0; bus_ack = 1'b0; settle();
    check("to_ld_rdata", mem_rdata, 32'h0BAD_CAFE);
    check("to_ld_err", mem_err, 0);

    // Reset pulse during WAIT, then rd+wr together
    step(); mem_rd = 1'b1; mem_addr = 32'h700; settle();
    step(); settle();
    check("rw_wait_req", bus_req, 1);
    rst_n = 1'b0;
    step(); settle();
    check("rw_rst_req", bus_req, 0);
    check("rw_rst_rdata", mem_rdata, 0);
    rst_n = 1'b1; mem_wr = 1'b1; mem_addr = 32'h800; mem_wdata = 32'h55; settle();
    check("rw_idle_stall", mem_stall, 1);
    check("rw_idle_req", bus_req, 0);
    step(); bus_ack = 1'b1; settle();
    check("rw_wait_we", bus_we, 1);
    check("rw_wait_addr", bus_addr, 32'h800);
    check("rw_wait_wdata", bus_wdata, 32'h55);
    step(); mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0; settle();
    check("rw_done_stall", mem_stall, 0);
    check("rw_done_rdata", mem_rdata, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
